// File: rtl/cic_pkg.sv
// Shared CIC helpers: width arithmetic and sign extension. The interpolator
// and the decimator both import this package.
package cic_pkg;

    localparam int MAX_W = 64;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

    // Full Hogenauer growth for differential delay M = 1.
    function automatic int out_width(input int in_w, input int n_stages, input int rw);
        return in_w + n_stages * rw;
    endfunction

    // Sign-extends the low w bits of v to MAX_W bits.
    function automatic logic [MAX_W-1:0] sext(input logic [MAX_W-1:0] v, input int w);
        return $signed(v << (MAX_W - w)) >>> (MAX_W - w);
    endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC comb section: combinational difference against a delay register
// that only advances on the output-rate strobe.
module cic_comb_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o
);

    logic [W-1:0] dly_q;

    assign dout_o = din_i - dly_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dly_q <= '0;
        end else if (en_i) begin
            dly_q <= din_i;
        end
    end

endmodule

// File: rtl/cic_decim_single.sv
// N-stage CIC decimator by R: pipelined integrators at the input rate, a
// combinational comb chain evaluated once per R accepted samples.
module cic_decim_single
    import cic_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int N     = 2,
    parameter int R     = 2,
    parameter int RW    = clog2(R),
    parameter int OUT_W = out_width(IN_W, N, RW)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic signed [IN_W-1:0]  x,
    output logic                    out_valid,
    output logic signed [OUT_W-1:0] y
);

    localparam int PH_W = (RW < 1) ? 1 : RW;

    logic [OUT_W-1:0] x_ext;
    logic [OUT_W-1:0] integ [N];
    logic [PH_W-1:0]  phase_q, phase_d;
    logic             last_phase;
    logic             dec_strobe_q;
    logic [OUT_W-1:0] samp_q;
    logic [OUT_W-1:0] comb [N+1];
    logic [OUT_W-1:0] y_q;
    logic             out_valid_q;

    assign x_ext = OUT_W'(sext(MAX_W'(x), IN_W));

    // Integrators wrap modulo 2^OUT_W; the combs cancel the wrap exactly.
    for (genvar k = 0; k < N; k++) begin : g_int
        logic [OUT_W-1:0] acc_q;
        logic [OUT_W-1:0] addend;

        if (k == 0) begin : g_first
            assign addend = x_ext;
        end else begin : g_next
            assign addend = integ[k-1];
        end

        // NOTE: non-blocking so every stage adds its neighbour's previous-cycle value.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                acc_q <= '0;
            end else if (in_valid) begin
                acc_q <= acc_q + addend;
            end
        end

        assign integ[k] = acc_q;
    end

    assign last_phase = in_valid && (phase_q == PH_W'(R - 1));

    // NOTE: default assignment first, so no path leaves phase_d unassigned (no latch).
    always_comb begin
        phase_d = phase_q;
        if (in_valid) begin
            phase_d = (phase_q == PH_W'(R - 1)) ? '0 : phase_q + PH_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q      <= '0;
            dec_strobe_q <= 1'b0;
            samp_q       <= '0;
        end else begin
            phase_q      <= phase_d;
            dec_strobe_q <= last_phase;
            if (last_phase) begin
                samp_q <= integ[N-1];
            end
        end
    end

    assign comb[0] = samp_q;

    for (genvar k = 0; k < N; k++) begin : g_comb
        cic_comb_stage #(
            .W (OUT_W)
        ) u_comb (
            .clk    (clk),
            .reset  (reset),
            .en_i   (dec_strobe_q),
            .din_i  (comb[k]),
            .dout_o (comb[k+1])
        );
    end

    // y holds between pulses; out_valid is the strobe delayed by one register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            y_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= dec_strobe_q;
            if (dec_strobe_q) begin
                y_q <= comb[N];
            end
        end
    end

    assign y         = y_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_cic_decim_single.sv
// Scoreboard bench for cic_decim_single: an N=2/R=2 and an N=3/R=8 instance
// checked against a direct FIR form of the CIC response.
module tb_cic_decim_single;

    localparam int IN_W = 8;
    localparam int N2   = 2;
    localparam int R2   = 2;
    localparam int OW2  = 10;
    localparam int N3   = 3;
    localparam int R3   = 8;
    localparam int OW3  = 17;
    localparam int HW   = 32;

    typedef struct {
        longint val;
        int     cyc;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   iv2, iv3;
    logic signed [IN_W-1:0] x2, x3;
    logic                   ov2, ov3;
    logic signed [OW2-1:0]  y2;
    logic signed [OW3-1:0]  y3;

    int     n_asrt = 0;
    int     n_fail = 0;
    int     cyc    = 0;
    longint hist [2][HW];
    longint hc   [2][HW];
    int     nst  [2] = '{N2, N3};
    int     rr   [2] = '{R2, R3};
    int     nacc [2];
    exp_t   exp2_q[$], exp3_q[$];
    longint got2[$], got3[$], ref_q[$];
    exp_t   e2, e3;
    logic   pv2 = 1'b0;
    logic   pv3 = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cic_decim_single #(.IN_W(IN_W), .N(N2), .R(R2)) u_dut2 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (iv2),
        .x         (x2),
        .out_valid (ov2),
        .y         (y2)
    );

    cic_decim_single #(.IN_W(IN_W), .N(N3), .R(R3)) u_dut3 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (iv3),
        .x         (x3),
        .out_valid (ov3),
        .y         (y3)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_asrt++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Coefficient k of (1 + z^-1 + ... + z^-(r-1))^n.
    function automatic longint coef(input int n, input int r, input int k);
        longint a [128];
        longint b [128];
        a = '{default: 0};
        a[0] = 1;
        for (int s = 0; s < n; s++) begin
            b = '{default: 0};
            for (int j = 0; j < 128; j++)
                for (int i = 0; i < r; i++)
                    if (j + i < 128) b[j+i] += a[j];
            a = b;
        end
        return a[k];
    endfunction

    function automatic int ramp(input int i);
        return (i % 256) - 128;
    endfunction

    task automatic model_clear();
        exp2_q.delete();
        exp3_q.delete();
        for (int s = 0; s < 2; s++) begin
            nacc[s] = 0;
            for (int i = 0; i < HW; i++) hist[s][i] = 0;
        end
    endtask

    // One cycle of stimulus; on accepted samples the model predicts any output.
    task automatic drive(input int sel, input bit v, input int xv);
        exp_t   e;
        longint acc;
        @(posedge clk);
        #1;
        iv2 = 1'b0;
        iv3 = 1'b0;
        if (v) begin
            if (sel == 0) begin
                iv2 = 1'b1;
                x2  = IN_W'(xv);
            end else begin
                iv3 = 1'b1;
                x3  = IN_W'(xv);
            end
            for (int i = 0; i < HW - 1; i++) hist[sel][i] = hist[sel][i+1];
            hist[sel][HW-1] = longint'(xv);
            if (nacc[sel] % rr[sel] == rr[sel] - 1) begin
                acc = 0;
                for (int k = 0; k + nst[sel] < HW; k++)
                    acc += hc[sel][k] * hist[sel][HW-1-nst[sel]-k];
                e.val = acc;
                e.cyc = cyc + 2;
                if (sel == 0) exp2_q.push_back(e);
                else          exp3_q.push_back(e);
            end
            nacc[sel]++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 1'b0, 0);
    endtask

    task automatic do_reset();
        check("drain", longint'(exp2_q.size() + exp3_q.size()), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        iv2   = 1'b0;
        iv3   = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        got2.delete();
        got3.delete();
    endtask

    always @(negedge clk) begin
        if (ov2) begin
            check("gap2", longint'(pv2), 0);
            if (exp2_q.size() == 0) begin
                check("extra2", longint'(exp2_q.size()), 1);
            end else begin
                e2 = exp2_q.pop_front();
                check("y2", y2, e2.val);
                check("lat2", cyc, e2.cyc);
            end
            got2.push_back(y2);
        end
        if (ov3) begin
            check("gap3", longint'(pv3), 0);
            if (exp3_q.size() == 0) begin
                check("extra3", longint'(exp3_q.size()), 1);
            end else begin
                e3 = exp3_q.pop_front();
                check("y3", y3, e3.val);
                check("lat3", cyc, e3.cyc);
            end
            got3.push_back(y3);
        end
        pv2 <= ov2;
        pv3 <= ov3;
    end

    initial begin
        int cnt;
        int i;
        int guard;

        reset = 1'b1;
        iv2   = 1'b0;
        iv3   = 1'b0;
        x2    = '0;
        x3    = '0;
        for (int s = 0; s < 2; s++)
            for (int k = 0; k < HW; k++)
                hc[s][k] = (k <= nst[s] * (rr[s] - 1)) ? coef(nst[s], rr[s], k) : 0;
        model_clear();
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        check("rst_y2", y2, 0);
        check("rst_ov2", longint'(ov2), 0);
        check("rst_y3", y3, 0);
        check("rst_ov3", longint'(ov3), 0);

        // Reset asserted mid-stream with in_valid high.
        repeat (9) drive(0, 1'b1, 5);
        check("pre_rst_y2", y2, 20);
        #2 reset = 1'b0;
        #1;
        check("midrst_y2", y2, 0);
        check("midrst_ov2", longint'(ov2), 0);
        model_clear();
        @(posedge clk);
        #1;
        iv2   = 1'b0;
        reset = 1'b1;
        got2.delete();
        drive(0, 1'b1, 3);
        drive(0, 1'b0, 0);
        drive(0, 1'b1, 3);
        idle(5);
        check("rst_first_cnt", longint'(got2.size()), 1);

        // DC steps.
        do_reset();
        repeat (20) drive(0, 1'b1, 1);
        idle(4);
        check("dc_p1", got2[$], 4);
        repeat (20) drive(0, 1'b1, -128);
        idle(4);
        check("dc_m128", got2[$], -512);
        repeat (20) drive(0, 1'b1, 127);
        idle(4);
        check("dc_p127", got2[$], 508);

        // Impulses at n = 0 and n = 1.
        do_reset();
        drive(0, 1'b1, 1);
        repeat (7) drive(0, 1'b1, 0);
        idle(4);
        check("imp0_cnt", longint'(got2.size()), 4);
        check("imp0_0", got2[0], 0);
        check("imp0_1", got2[1], 2);
        check("imp0_2", got2[2], 0);
        check("imp0_3", got2[3], 0);
        do_reset();
        drive(0, 1'b1, 0);
        drive(0, 1'b1, 1);
        repeat (6) drive(0, 1'b1, 0);
        idle(4);
        check("imp1_0", got2[0], 0);
        check("imp1_1", got2[1], 1);
        check("imp1_2", got2[2], 1);
        check("imp1_3", got2[3], 0);

        // Long full-scale run: integrators wrap many times.
        do_reset();
        repeat (20000) drive(0, 1'b1, 127);
        idle(4);
        check("wrap_cnt", longint'(got2.size()), 10000);
        cnt = 0;
        for (int k = 2; k < got2.size(); k++)
            if (got2[k] != 508) cnt++;
        check("wrap_glitches", cnt, 0);

        // Ungapped vs gapped ramp must produce identical outputs.
        do_reset();
        for (int k = 0; k < 200; k++) drive(0, 1'b1, ramp(k));
        idle(4);
        ref_q = got2;
        check("ramp_cnt", longint'(ref_q.size()), 100);
        do_reset();
        i     = 0;
        guard = 0;
        while (i < 200 && guard < 5000) begin
            if ($urandom_range(0, 99) < 30) begin
                drive(0, 1'b1, ramp(i));
                i++;
            end else begin
                drive(0, 1'b0, 0);
            end
            guard++;
        end
        idle(4);
        check("gap_accepted", i, 200);
        check("gap_cnt", longint'(got2.size()), 100);
        cnt = 0;
        for (int k = 0; k < got2.size() && k < ref_q.size(); k++)
            if (got2[k] != ref_q[k]) cnt++;
        check("gap_vs_ungapped", cnt, 0);

        // N=3, R=8: random gapped stimulus, then full-scale extremes.
        do_reset();
        i     = 0;
        guard = 0;
        while (i < 400 && guard < 5000) begin
            if ($urandom_range(0, 99) < 70) begin
                drive(1, 1'b1, int'($urandom_range(0, 255)) - 128);
                i++;
            end else begin
                drive(0, 1'b0, 0);
            end
            guard++;
        end
        idle(6);
        check("n3_accepted", i, 400);
        check("n3_cnt", longint'(got3.size()), 50);
        repeat (64) drive(1, 1'b1, -128);
        idle(6);
        check("n3_min", got3[$], -65536);
        repeat (64) drive(1, 1'b1, 127);
        idle(6);
        check("n3_max", got3[$], 65024);

        check("sb2_empty", longint'(exp2_q.size()), 0);
        check("sb3_empty", longint'(exp3_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
